// File: rtl/keypad_scanner.sv
// 4x4 hex keypad scanner: drives one-cold row strobes, samples active-low column
// returns, debounces across whole scans and shifts accepted digits into a
// 16-bit entry register sized for the seven-segment display value input.
module keypad_scanner #(
  parameter int SCAN_DIV       = 2048,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  col,
  input  logic        clear,
  output logic [3:0]  row,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_held,
  output logic [15:0] value
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] STAB_MAX   = CW'(DEBOUNCE_SCANS);

  // Classification of one complete 16-position scan; also the debounce candidate.
  typedef enum logic [1:0] {
    RES_NONE   = 2'd0,
    RES_SINGLE = 2'd1,
    RES_MULTI  = 2'd2
  } res_e;

  logic [3:0]    col_meta_q, col_meta_d;
  logic [3:0]    col_sync_q, col_sync_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    row_idx_q, row_idx_d;
  logic [15:0]   scan_acc_q, scan_acc_d;
  logic          eval_q, eval_d;
  res_e          cand_kind_q, cand_kind_d;
  logic [3:0]    cand_code_q, cand_code_d;
  logic [CW-1:0] stab_cnt_q, stab_cnt_d;
  logic [3:0]    key_code_q, key_code_d;
  logic          key_valid_q, key_valid_d;
  logic          key_held_q, key_held_d;
  logic [15:0]   value_q, value_d;

  res_e          res_kind;
  logic [3:0]    res_code;
  logic [1:0]    hits;
  logic [3:0]    hit_pos;
  logic          same;
  logic          accept;

  // Position {row, col} to hex digit as printed on the keypad.
  function automatic logic [3:0] key_map(input logic [3:0] pos);
    logic [3:0] k;
    case (pos)
      4'd0:    k = 4'h1;
      4'd1:    k = 4'h2;
      4'd2:    k = 4'h3;
      4'd3:    k = 4'hA;
      4'd4:    k = 4'h4;
      4'd5:    k = 4'h5;
      4'd6:    k = 4'h6;
      4'd7:    k = 4'hB;
      4'd8:    k = 4'h7;
      4'd9:    k = 4'h8;
      4'd10:   k = 4'h9;
      4'd11:   k = 4'hC;
      4'd12:   k = 4'h0;
      4'd13:   k = 4'hF;
      4'd14:   k = 4'hE;
      default: k = 4'hD;
    endcase
    return k;
  endfunction

  // Classify the accumulated scan (bit set = position pressed); hit count saturates at 2.
  always_comb begin
    hits     = 2'd0;
    hit_pos  = 4'd0;
    res_kind = RES_NONE;
    res_code = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (scan_acc_q[i]) begin
        if (hits != 2'd2) hits = hits + 2'd1;
        hit_pos = 4'(i);
      end
    end
    if (hits == 2'd1) begin
      res_kind = RES_SINGLE;
      res_code = key_map(hit_pos);
    end else if (hits == 2'd2) begin
      res_kind = RES_MULTI;
    end
  end

  // Next state: synchroniser, prescaler/row strobe, sampling, debounce and acceptance.
  always_comb begin
    col_meta_d  = col;
    col_sync_d  = col_meta_q;
    presc_d     = presc_q;
    row_idx_d   = row_idx_q;
    scan_acc_d  = scan_acc_q;
    eval_d      = 1'b0;
    cand_kind_d = cand_kind_q;
    cand_code_d = cand_code_q;
    stab_cnt_d  = stab_cnt_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    value_d     = value_q;
    same        = 1'b0;
    accept      = 1'b0;

    if (presc_q == PRESC_LAST) begin
      presc_d    = '0;
      row_idx_d  = row_idx_q + 2'd1;
      scan_acc_d[{row_idx_q, 2'b00} +: 4] = ~col_sync_q;
      eval_d     = (row_idx_q == 2'd3);
    end else begin
      presc_d = presc_q + PW'(1);
    end

    if (eval_q) begin
      same = (res_kind == cand_kind_q) &&
             ((res_kind != RES_SINGLE) || (res_code == cand_code_q));
      if (same) begin
        if (stab_cnt_q != STAB_MAX) stab_cnt_d = stab_cnt_q + CW'(1);
      end else begin
        cand_kind_d = res_kind;
        cand_code_d = res_code;
        stab_cnt_d  = CW'(1);
      end
      // Act only on the scan that makes the result stable, never while merely staying stable.
      accept = (stab_cnt_d == STAB_MAX) && (!same || (stab_cnt_q != STAB_MAX));
      if (accept) begin
        case (res_kind)
          RES_SINGLE: begin
            if (!key_held_q) begin
              key_code_d  = res_code;
              key_held_d  = 1'b1;
              key_valid_d = 1'b1;
              value_d     = {value_q[11:0], res_code};
            end
          end
          RES_NONE: key_held_d = 1'b0;
          default:  ;
        endcase
      end
    end

    // Clear takes priority over a digit accepted in the same cycle.
    if (clear) value_d = '0;
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      col_meta_q  <= 4'hF;
      col_sync_q  <= 4'hF;
      presc_q     <= '0;
      row_idx_q   <= 2'd0;
      scan_acc_q  <= '0;
      eval_q      <= 1'b0;
      cand_kind_q <= RES_NONE;
      cand_code_q <= 4'd0;
      stab_cnt_q  <= '0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      value_q     <= '0;
    end else begin
      col_meta_q  <= col_meta_d;
      col_sync_q  <= col_sync_d;
      presc_q     <= presc_d;
      row_idx_q   <= row_idx_d;
      scan_acc_q  <= scan_acc_d;
      eval_q      <= eval_d;
      cand_kind_q <= cand_kind_d;
      cand_code_q <= cand_code_d;
      stab_cnt_q  <= stab_cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
      value_q     <= value_d;
    end
  end

  assign row       = ~(4'b0001 << row_idx_q);
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;
  assign value     = value_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_SCANS=2 (16-cycle scans).
// A keypad model turns a pressed-position mask into column returns; accepted
// keys are queued when pressed and compared when key_valid pulses.
module tb_keypad_scanner;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  col;
  logic        clear;
  logic [3:0]  row;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] value;

  logic [15:0] press_mask;
  logic [15:0] model_value;
  int          checks   = 0;
  int          failures = 0;
  int          pulses   = 0;
  int unsigned edge_cnt;

  typedef struct {
    logic [3:0]  code;
    logic [15:0] value;
  } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;

  logic [3:0] key_tab [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                               4'h4, 4'h5, 4'h6, 4'hB,
                               4'h7, 4'h8, 4'h9, 4'hC,
                               4'h0, 4'hF, 4'hE, 4'hD};

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2)) dut (
    .clock(clock), .reset(reset), .col(col), .clear(clear), .row(row),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held), .value(value)
  );

  always #5 clock = ~clock;

  // Keypad matrix: a pressed key pulls its column low while its row is strobed.
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row[r] && press_mask[r*4+c]) col[c] = 1'b0;
  end

  // Edge count since reset release; scans start every 16 edges.
  always @(posedge clock or posedge reset) begin
    if (reset) edge_cnt <= 0;
    else       edge_cnt <= edge_cnt + 1;
  end

  // Scoreboard monitor: every pulse must match the oldest expected key.
  always @(negedge clock) begin
    if (!reset && key_valid === 1'b1) begin
      pulses++;
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse: got key_code=%h value=%h, expected no pulse", key_code, value);
      end else begin
        mon_e = sb_q.pop_front();
        checks++;
        if (key_code !== mon_e.code) begin
          failures++;
          $display("FAIL pulse_key_code: got %h expected %h", key_code, mon_e.code);
        end
        checks++;
        if (value !== mon_e.value) begin
          failures++;
          $display("FAIL pulse_value: got %h expected %h", value, mon_e.value);
        end
        checks++;
        if ((edge_cnt % 16) != 1) begin
          failures++;
          $display("FAIL pulse_latency: edge %0d mod 16 = %0d expected 1", edge_cnt, edge_cnt % 16);
        end
      end
    end
  end

  function automatic logic [15:0] key_mask(input logic [3:0] code);
    logic [15:0] m;
    m = '0;
    for (int p = 0; p < 16; p++) if (key_tab[p] == code) m[p] = 1'b1;
    return m;
  endfunction

  task automatic expect_key(input logic [3:0] code, input bit cleared);
    exp_t e;
    model_value = cleared ? 16'h0000 : {model_value[11:0], code};
    e.code  = code;
    e.value = model_value;
    sb_q.push_back(e);
  endtask

  // Hold a press mask for n whole scans, starting on a scan boundary.
  task automatic hold(input logic [15:0] m, input int n);
    while ((edge_cnt % 16) != 0) @(negedge clock);
    press_mask = m;
    repeat (16 * n) @(negedge clock);
  endtask

  task automatic test_reset;
    logic [3:0] er;
    reset = 1'b1; clear = 1'b0; press_mask = '0; model_value = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 64; i++) begin
      er = ~(4'b0001 << ((edge_cnt >> 2) & 3));
      checks++;
      if (row !== er) begin
        failures++;
        $display("FAIL reset_row_cycle: edge %0d got row=%b expected %b", edge_cnt, row, er);
      end
      @(negedge clock);
    end
    checks++;
    if (value !== 16'h0000 || key_held !== 1'b0 || key_code !== 4'h0 || pulses != 0) begin
      failures++;
      $display("FAIL reset_idle: value=%h held=%b code=%h pulses=%0d, expected 0000 0 0 0", value, key_held, key_code, pulses);
    end
  endtask

  task automatic test_single_key;
    int p0 = pulses;
    expect_key(4'h5, 1'b0);
    hold(key_mask(4'h5), 3);
    checks++;
    if (pulses - p0 != 1 || key_code !== 4'h5 || key_held !== 1'b1 || value !== 16'h0005) begin
      failures++;
      $display("FAIL single_key: pulses=%0d code=%h held=%b value=%h, expected 1 5 1 0005", pulses - p0, key_code, key_held, value);
    end
    hold(16'h0000, 3);
    checks++;
    if (pulses - p0 != 1 || key_held !== 1'b0 || key_code !== 4'h5) begin
      failures++;
      $display("FAIL single_release: pulses=%0d held=%b code=%h, expected 1 0 5", pulses - p0, key_held, key_code);
    end
  endtask

  task automatic test_entry;
    logic [3:0] seq [5] = '{4'h1, 4'hA, 4'h3, 4'hF, 4'h7};
    int p0 = pulses;
    for (int i = 0; i < 5; i++) begin
      expect_key(seq[i], 1'b0);
      hold(key_mask(seq[i]), 3);
      hold(16'h0000, 3);
    end
    checks++;
    if (value !== 16'hA3F7 || pulses - p0 != 5 || sb_q.size() != 0) begin
      failures++;
      $display("FAIL entry_sequence: value=%h pulses=%0d pending=%0d, expected A3F7 5 0", value, pulses - p0, sb_q.size());
    end
  endtask

  task automatic test_bounce;
    int p0 = pulses;
    for (int i = 0; i < 3; i++) begin
      hold(key_mask(4'h8), 1);
      hold(16'h0000, 1);
    end
    checks++;
    if (pulses != p0 || key_held !== 1'b0) begin
      failures++;
      $display("FAIL bounce_reject: pulses=%0d held=%b, expected 0 0", pulses - p0, key_held);
    end
    expect_key(4'h8, 1'b0);
    hold(key_mask(4'h8), 2);
    repeat (2) @(negedge clock);
    checks++;
    if (pulses - p0 != 1 || key_code !== 4'h8 || key_held !== 1'b1) begin
      failures++;
      $display("FAIL bounce_accept: pulses=%0d code=%h held=%b, expected 1 8 1", pulses - p0, key_code, key_held);
    end
    hold(16'h0000, 3);
  endtask

  task automatic test_multi_no_repeat;
    int p0 = pulses;
    hold(key_mask(4'h2) | key_mask(4'h6), 3);
    checks++;
    if (pulses != p0 || key_held !== 1'b0 || key_code !== 4'h8) begin
      failures++;
      $display("FAIL multi_reject: pulses=%0d held=%b code=%h, expected 0 0 8", pulses - p0, key_held, key_code);
    end
    expect_key(4'hD, 1'b0);
    hold(key_mask(4'hD), 10);
    checks++;
    if (pulses - p0 != 1 || key_code !== 4'hD) begin
      failures++;
      $display("FAIL hold_no_repeat: pulses=%0d code=%h, expected 1 D", pulses - p0, key_code);
    end
    hold(key_mask(4'hE), 3);
    checks++;
    if (pulses - p0 != 1 || key_code !== 4'hD || key_held !== 1'b1) begin
      failures++;
      $display("FAIL rollover_change: pulses=%0d code=%h held=%b, expected 1 D 1", pulses - p0, key_code, key_held);
    end
    hold(16'h0000, 3);
  endtask

  task automatic test_clear_reset;
    int p0 = pulses;
    checks++;
    if (value !== model_value) begin
      failures++;
      $display("FAIL value_before_clear: got %h expected %h", value, model_value);
    end
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    model_value = '0;
    checks++;
    if (value !== 16'h0000) begin
      failures++;
      $display("FAIL clear_idle: got value=%h expected 0000", value);
    end
    expect_key(4'hC, 1'b1);
    clear = 1'b1;
    hold(key_mask(4'hC), 3);
    clear = 1'b0;
    checks++;
    if (pulses - p0 != 1 || value !== 16'h0000 || key_code !== 4'hC || key_held !== 1'b1) begin
      failures++;
      $display("FAIL clear_with_valid: pulses=%0d value=%h code=%h held=%b, expected 1 0000 C 1", pulses - p0, value, key_code, key_held);
    end
    // Switch to '5' and abort mid-debounce.
    hold(key_mask(4'h5), 1);
    repeat (5) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (row !== 4'b1110 || key_code !== 4'h0 || key_valid !== 1'b0 || key_held !== 1'b0 || value !== 16'h0000) begin
      failures++;
      $display("FAIL async_reset: row=%b code=%h valid=%b held=%b value=%h, expected 1110 0 0 0 0000", row, key_code, key_valid, key_held, value);
    end
    @(negedge clock);
    reset = 1'b0;
    press_mask = '0;
    model_value = '0;
    hold(16'h0000, 3);
    checks++;
    if (pulses - p0 != 1 || key_held !== 1'b0 || value !== 16'h0000 || sb_q.size() != 0) begin
      failures++;
      $display("FAIL after_reset: pulses=%0d held=%b value=%h pending=%0d, expected 1 0 0000 0", pulses - p0, key_held, value, sb_q.size());
    end
  endtask

  initial begin
    reset = 1'b1;
    clear = 1'b0;
    press_mask = '0;
    model_value = '0;
    test_reset();
    test_single_key();
    test_entry();
    test_bounce();
    test_multi_no_repeat();
    test_clear_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
